dmem_port_arbiter: RTL

Sequencer and arbiter for the single read/write port of the synchronous-read data memory used by the MEM stage. It shares the port between the CPU pipeline and a debug/loader port. It performs sub-word stores (SB/SH) as read-modify-write sequences, and raises a stall to the pipeline while a CPU access is outstanding. It sits between the MEM stage and the data memory; the memory's second, read-only display port is not touched.

---
 rtl/dmem_port_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter
// Brief    : Shares the data-memory port between CPU and debug; sub-word
//            stores as read-modify-write when DMEM_RMW_EN is defined.
// Revision : 1.0
// ============================================================================
module dmem_port_arbiter #(
    parameter int DBG_MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_size,
    input  logic [8:0]  cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [6:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_rdata,
    output logic        dbg_ack,
    output logic [6:0]  mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = $clog2(DBG_MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RMW_RD  = 2'd2,
        RMW_WR  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_owner_dbg;
    logic [6:0]         r_addr;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic               w_wait_full;
    logic               w_grant_dbg;
    logic               w_grant_cpu;
    logic               w_cpu_word_wr;
    logic [31:0]        w_cpu_store;

    assign w_wait_full = (r_wait_cnt == CNT_W'(DBG_MAX_WAIT));
    assign w_grant_dbg = rst_n && (r_state == IDLE) && dbg_req && (!cpu_req || w_wait_full);
    assign w_grant_cpu = rst_n && (r_state == IDLE) && !w_grant_dbg && cpu_req;

`ifdef DMEM_RMW_EN
    logic [1:0]  r_lane;
    logic        r_half;
    logic [15:0] r_wdata;
    logic [31:0] r_merge;
    logic [31:0] w_merged;

    assign w_cpu_word_wr = cpu_we && cpu_size[1];
    assign w_cpu_store   = cpu_wdata;

    // Little-endian lane replacement over the word just read back.
    always_comb begin
        w_merged = mem_rdata;
        if (r_half) begin
            if (r_lane[1]) w_merged[31:16] = r_wdata;
            else           w_merged[15:0]  = r_wdata;
        end else begin
            w_merged[8*r_lane +: 8] = r_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lane  <= 2'b00;
            r_half  <= 1'b0;
            r_wdata <= 16'h0000;
            r_merge <= 32'h0000_0000;
        end else begin
            if (w_grant_cpu) begin
                r_lane  <= cpu_addr[1:0];
                r_half  <= cpu_size[0];
                r_wdata <= cpu_wdata[15:0];
            end
            if (r_state == RMW_RD) r_merge <= w_merged;
        end
    end
`else
    logic w_unused_lane;

    // Without RMW, narrow stores become zero-extended full-word writes.
    assign w_cpu_word_wr = cpu_we;
    assign w_unused_lane = &{1'b0, cpu_addr[1:0]};
    always_comb begin
        case (cpu_size)
            2'b00:   w_cpu_store = {24'h000000, cpu_wdata[7:0]};
            2'b01:   w_cpu_store = {16'h0000, cpu_wdata[15:0]};
            default: w_cpu_store = cpu_wdata;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        mem_addr  = 7'h00;
        mem_we    = 1'b0;
        mem_wdata = 32'h0000_0000;
        cpu_ack   = 1'b0;
        dbg_ack   = 1'b0;
        cpu_rdata = 32'h0000_0000;
        dbg_rdata = 32'h0000_0000;
        if (rst_n) begin
            case (r_state)
                IDLE: begin
                    if (w_grant_dbg) begin
                        mem_addr = dbg_addr;
                        if (dbg_we) begin
                            mem_we    = 1'b1;
                            mem_wdata = dbg_wdata;
                            dbg_ack   = 1'b1;
                        end else begin
                            w_next = RD_WAIT;
                        end
                    end else if (w_grant_cpu) begin
                        mem_addr = cpu_addr[8:2];
                        if (w_cpu_word_wr) begin
                            mem_we    = 1'b1;
                            mem_wdata = w_cpu_store;
                            cpu_ack   = 1'b1;
                        end
`ifdef DMEM_RMW_EN
                        else if (cpu_we) begin
                            w_next = RMW_RD;
                        end
`endif
                        else begin
                            w_next = RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    mem_addr = r_addr;
                    w_next   = IDLE;
                    if (r_owner_dbg) begin
                        dbg_ack   = 1'b1;
                        dbg_rdata = mem_rdata;
                    end else begin
                        cpu_ack   = 1'b1;
                        cpu_rdata = mem_rdata;
                    end
                end
`ifdef DMEM_RMW_EN
                RMW_RD: begin
                    mem_addr = r_addr;
                    w_next   = RMW_WR;
                end
                RMW_WR: begin
                    mem_addr  = r_addr;
                    mem_we    = 1'b1;
                    mem_wdata = r_merge;
                    cpu_ack   = 1'b1;
                    w_next    = IDLE;
                end
`endif
                default: w_next = IDLE;
            endcase
        end
    end

    assign cpu_stall = rst_n && cpu_req && !cpu_ack;

    // Owner and word index are held so an access finishes even if req drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner_dbg <= 1'b0;
            r_addr      <= 7'h00;
            r_wait_cnt  <= '0;
        end else begin
            if (w_grant_dbg || w_grant_cpu) begin
                r_owner_dbg <= w_grant_dbg;
                r_addr      <= w_grant_dbg ? dbg_addr : cpu_addr[8:2];
            end
            if (!dbg_req || w_grant_dbg)
                r_wait_cnt <= '0;
            else if (w_grant_cpu && !w_wait_full)
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire
